fifo_flow_ctrl: RTL and testbench

- Synchronous FIFO with watermark flow-control flags; one instance per virtual channel, four instances feed the flow-control FSM (pause/continue/empty/error/full per FIFO).
- Buffers TLP words from the ingress side and generates the status bits the FSM consumes: almost-full (pause), almost-empty (continue), empty, full, and sticky error.
- Read side is popped by the downstream arbiter.

---
 rtl/fifo_flow_ctrl_pkg.sv | 8 +
 rtl/fifo_flow_ctrl_mem.sv | 31 +++
 rtl/fifo_flow_ctrl.sv | 78 +++++++
 tb/tb_fifo_flow_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared defaults for the per-virtual-channel flow-control FIFOs:
// storage geometry and the watermark thresholds used by the FSM.
package fifo_flow_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 10;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int TH_HIGH_DEF    = 6;
  localparam int TH_LOW_DEF     = 2;
endpackage

// File: rtl/fifo_flow_ctrl_mem.sv
// Dual-port register array with a registered read port.
// The array holds no reset state; only the read register clears.
module fifo_mem
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with watermark flags (pause/continue/empty/full)
// and a sticky overflow/underflow error for the flow-control FSM.
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   th_high,
  input  logic [ADDR_WIDTH:0]   th_low,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_pause,
  output logic                  fifo_continue,
  output logic                  fifo_error
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  err_set;

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CNT_W'(DEPTH));
  assign fifo_pause    = (count >= th_high);
  assign fifo_continue = (count <= th_low);

  // A full FIFO still takes a push when the same edge frees a slot;
  // an empty FIFO never forwards the incoming word to the read side.
  assign pop_ok  = pop && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);
  assign err_set = (push && fifo_full && !pop_ok) || (pop && fifo_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      valid_out <= pop_ok;
      if (err_set) fifo_error <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl: a queue-based reference FIFO
// predicts occupancy, flags, error and read data after every edge.
module tb_fifo_flow_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [3:0] th_high;
  logic [3:0] th_low;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       fifo_empty, fifo_full, fifo_pause, fifo_continue, fifo_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] model_q[$];
  logic [9:0] m_dout;
  logic       m_err;

  always #5 clk = ~clk;

  fifo_flow_ctrl #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .data_in       (data_in),
    .pop           (pop),
    .th_high       (th_high),
    .th_low        (th_low),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .count         (count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_pause    (fifo_pause),
    .fifo_continue (fifo_continue),
    .fifo_error    (fifo_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic exp_vld);
    int c;
    c = model_q.size();
    chk("count",    32'(count),         32'(c));
    chk("empty",    32'(fifo_empty),    32'(c == 0));
    chk("full",     32'(fifo_full),     32'(c == 8));
    chk("pause",    32'(fifo_pause),    32'(c >= int'(th_high)));
    chk("continue", 32'(fifo_continue), 32'(c <= int'(th_low)));
    chk("error",    32'(fifo_error),    32'(m_err));
    chk("valid",    32'(valid_out),     32'(exp_vld));
    chk("data_out", 32'(data_out),      32'(m_dout));
  endtask

  task automatic step(input logic p, input logic [9:0] d, input logic q);
    int   c;
    logic pok;
    logic uok;
    @(negedge clk);
    push = p; data_in = d; pop = q;
    c   = model_q.size();
    pok = q && (c > 0);
    uok = p && ((c < 8) || pok);
    if ((p && c == 8 && !pok) || (q && c == 0)) m_err = 1'b1;
    @(posedge clk);
    #1;
    if (pok) m_dout = model_q.pop_front();
    if (uok) model_q.push_back(d);
    check_all(pok);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_q.delete();
    m_err  = 1'b0;
    m_dout = '0;
    check_all(1'b0);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    th_high = 4'd6; th_low = 4'd2;
    m_err = 1'b0; m_dout = '0;
    repeat (2) @(posedge clk);
    #1 check_all(1'b0);
    @(negedge clk) reset = 1'b1;

    step(1'b0, 10'h000, 1'b0);

    // Watermarks on a six-word burst, then in-order readback
    for (int i = 1; i <= 6; i++) step(1'b1, 10'(i), 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b0, 10'h000, 1'b1);

    // Overflow: dropped word, sticky error; live threshold changes
    for (int i = 0; i < 8; i++) step(1'b1, 10'h100 + 10'(i), 1'b0);
    step(1'b1, 10'h3FF, 1'b0);
    th_high = 4'd0; th_low = 4'd8;
    step(1'b0, 10'h000, 1'b0);
    th_high = 4'd6; th_low = 4'd2;
    for (int i = 0; i < 8; i++) step(1'b0, 10'h000, 1'b1);

    // Full push+pop together, then drain across the pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 10'h200 + 10'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 10'h155, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 10'h000, 1'b1);

    // Underflow with and without a simultaneous push
    reset_pulse();
    step(1'b0, 10'h000, 1'b1);
    step(1'b1, 10'h0AA, 1'b1);
    step(1'b0, 10'h000, 1'b1);

    // Asynchronous reset mid-operation at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 10'h040 + 10'(i), 1'b0);
    reset_pulse();
    step(1'b1, 10'h011, 1'b0);
    step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
